// File: rtl/snitch_pkg.sv
// Shared Snitch/MemPool type definitions.
// Holds the core meta id type and the reorder-buffer slot types used by
// mempool_tcdm_rob.
package snitch_pkg;

    // Core-side transaction id carried alongside every TCDM request.
    typedef logic [5:0] meta_id_t;

    // Lifecycle of one reorder-buffer slot.
    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_DONE = 2'd2
    } rob_state_e;

    // Response payload captured from memory for one slot.
    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } rob_slot_t;

endpackage

// File: rtl/mempool_tcdm_rob_if.sv
// One TCDM link: request channel (q*) and response channel (p*).
// The master side issues requests and accepts responses; the slave side
// accepts requests and produces responses.
interface mempool_tcdm_rob_if #(
    parameter int unsigned MetaIdWidth = $bits(snitch_pkg::meta_id_t)
) ();
    logic [31:0]            qaddr;
    logic                   qwrite;
    logic [3:0]             qamo;
    logic [31:0]            qdata;
    logic [3:0]             qstrb;
    logic [MetaIdWidth-1:0] qid;
    logic                   qvalid;
    logic                   qready;
    logic [31:0]            pdata;
    logic                   perror;
    logic [MetaIdWidth-1:0] pid;
    logic                   pvalid;
    logic                   pready;

    modport master (
        output qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
        input  qready, pdata, perror, pid, pvalid
    );

    modport slave (
        input  qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
        output qready, pdata, perror, pid, pvalid
    );
endinterface

// File: rtl/mempool_tcdm_rob.sv
// TCDM reorder buffer: forwards core requests to memory tagged with a slot
// index, collects out-of-order memory responses and returns them to the core
// in issue order.
// Optional build macro: MEMPOOL_TCDM_ROB_STATS_EN adds full_stall_cnt_o, a
// saturating count of cycles where the core wants to issue but all slots
// are occupied.
module mempool_tcdm_rob
    import snitch_pkg::*;
#(
    parameter int unsigned NumSlots    = 4,
    parameter int unsigned MetaIdWidth = $bits(meta_id_t)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // Core request
    input  logic [31:0]            core_qaddr_i,
    input  logic                   core_qwrite_i,
    input  logic [3:0]             core_qamo_i,
    input  logic [31:0]            core_qdata_i,
    input  logic [3:0]             core_qstrb_i,
    input  logic [MetaIdWidth-1:0] core_qid_i,
    input  logic                   core_qvalid_i,
    output logic                   core_qready_o,
    // Core response (in order)
    output logic [31:0]            core_pdata_o,
    output logic                   core_perror_o,
    output logic [MetaIdWidth-1:0] core_pid_o,
    output logic                   core_pvalid_o,
    input  logic                   core_pready_i,
    // Memory request
    output logic [31:0]            mem_qaddr_o,
    output logic                   mem_qwrite_o,
    output logic [3:0]             mem_qamo_o,
    output logic [31:0]            mem_qdata_o,
    output logic [3:0]             mem_qstrb_o,
    output logic [MetaIdWidth-1:0] mem_qid_o,
    output logic                   mem_qvalid_o,
    input  logic                   mem_qready_i,
    // Memory response (out of order)
    input  logic [31:0]            mem_pdata_i,
    input  logic                   mem_perror_i,
    input  logic [MetaIdWidth-1:0] mem_pid_i,
    input  logic                   mem_pvalid_i,
    output logic                   mem_pready_o,
    // Sticky: a response arrived for a slot that was not waiting for one
    output logic                   spurious_o
`ifdef MEMPOOL_TCDM_ROB_STATS_EN
    ,
    output logic [31:0]            full_stall_cnt_o
`endif
);

    localparam int unsigned PtrW = $clog2(NumSlots);
    localparam int unsigned CntW = $clog2(NumSlots) + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    rob_state_e             state_q [NumSlots];
    rob_state_e             state_d [NumSlots];
    rob_slot_t              slot_q  [NumSlots];
    rob_slot_t              slot_d  [NumSlots];
    logic [MetaIdWidth-1:0] id_q    [NumSlots];
    logic [MetaIdWidth-1:0] id_d    [NumSlots];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic spurious_q, spurious_d;

    logic not_full;
    logic alloc;
    logic pop;
    logic pid_in_range;
    ptr_t resp_idx;
    logic resp_hit;

    // Occupancy comes only from registered state, so a pop never frees a
    // slot for an allocation in the same cycle.
    assign not_full      = (count_q != cnt_t'(NumSlots));
    assign mem_qvalid_o  = core_qvalid_i & not_full;
    assign core_qready_o = mem_qready_i & not_full;
    assign alloc         = core_qvalid_i & mem_qready_i & not_full;

    assign mem_qaddr_o  = core_qaddr_i;
    assign mem_qwrite_o = core_qwrite_i;
    assign mem_qamo_o   = core_qamo_i;
    assign mem_qdata_o  = core_qdata_i;
    assign mem_qstrb_o  = core_qstrb_i;
    assign mem_qid_o    = MetaIdWidth'(wr_ptr_q);
    assign mem_pready_o = 1'b1;

    // Ids beyond the slot range can never match an allocated slot.
    assign pid_in_range = ((mem_pid_i >> PtrW) == '0);
    assign resp_idx     = mem_pid_i[PtrW-1:0];
    assign resp_hit     = mem_pvalid_i & pid_in_range & (state_q[resp_idx] == SLOT_PEND);

    // The head is presented straight from registered slot state, so a
    // memory response reaches the core no earlier than the next cycle.
    assign core_pvalid_o = (state_q[rd_ptr_q] == SLOT_DONE);
    assign core_pdata_o  = slot_q[rd_ptr_q].data;
    assign core_perror_o = slot_q[rd_ptr_q].error;
    assign core_pid_o    = id_q[rd_ptr_q];
    assign pop           = core_pvalid_o & core_pready_i;

    assign spurious_o = spurious_q;

    // Next-state for slot states, pointers, occupancy and the sticky flag.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        spurious_d = spurious_q | (mem_pvalid_i & ~resp_hit);
        if (alloc) begin
            state_d[wr_ptr_q] = SLOT_PEND;
            wr_ptr_d          = wr_ptr_q + ptr_t'(1);
        end
        if (resp_hit) begin
            state_d[resp_idx] = SLOT_DONE;
        end
        if (pop) begin
            state_d[rd_ptr_q] = SLOT_FREE;
            rd_ptr_d          = rd_ptr_q + ptr_t'(1);
        end
        case ({alloc, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state for slot payload: core id on allocation, response on hit.
    always_comb begin
        slot_d = slot_q;
        id_d   = id_q;
        if (alloc) begin
            id_d[wr_ptr_q] = core_qid_i;
        end
        if (resp_hit) begin
            slot_d[resp_idx].data  = mem_pdata_i;
            slot_d[resp_idx].error = mem_perror_i;
        end
    end

    // Control state; reset discards every outstanding slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumSlots); i++) begin
                state_q[i] <= SLOT_FREE;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
        end
    end

    // Payload storage; only read while the owning slot is DONE, so no reset.
    always_ff @(posedge clk_i) begin
        slot_q <= slot_d;
        id_q   <= id_d;
    end

`ifdef MEMPOOL_TCDM_ROB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the core is held off by a full buffer.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (core_qvalid_i && !not_full && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign full_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mempool_tcdm_rob.sv
// Self-checking bench for mempool_tcdm_rob: in-order return of out-of-order
// responses, full-buffer back-pressure, same-cycle pop/allocate, spurious
// responses, response stability under back-pressure and reset flushing.
module tb_mempool_tcdm_rob;
    import snitch_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned IW = $bits(meta_id_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spurious;
`ifdef MEMPOOL_TCDM_ROB_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mempool_tcdm_rob_if #(.MetaIdWidth(IW)) core_if ();
    mempool_tcdm_rob_if #(.MetaIdWidth(IW)) mem_if ();

    mempool_tcdm_rob #(.NumSlots(NS), .MetaIdWidth(IW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .core_qaddr_i  (core_if.qaddr),
        .core_qwrite_i (core_if.qwrite),
        .core_qamo_i   (core_if.qamo),
        .core_qdata_i  (core_if.qdata),
        .core_qstrb_i  (core_if.qstrb),
        .core_qid_i    (core_if.qid),
        .core_qvalid_i (core_if.qvalid),
        .core_qready_o (core_if.qready),
        .core_pdata_o  (core_if.pdata),
        .core_perror_o (core_if.perror),
        .core_pid_o    (core_if.pid),
        .core_pvalid_o (core_if.pvalid),
        .core_pready_i (core_if.pready),
        .mem_qaddr_o   (mem_if.qaddr),
        .mem_qwrite_o  (mem_if.qwrite),
        .mem_qamo_o    (mem_if.qamo),
        .mem_qdata_o   (mem_if.qdata),
        .mem_qstrb_o   (mem_if.qstrb),
        .mem_qid_o     (mem_if.qid),
        .mem_qvalid_o  (mem_if.qvalid),
        .mem_qready_i  (mem_if.qready),
        .mem_pdata_i   (mem_if.pdata),
        .mem_perror_i  (mem_if.perror),
        .mem_pid_i     (mem_if.pid),
        .mem_pvalid_i  (mem_if.pvalid),
        .mem_pready_o  (mem_if.pready),
        .spurious_o    (spurious)
`ifdef MEMPOOL_TCDM_ROB_STATS_EN
        ,
        .full_stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   data;
        logic          err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] slot_data [NS];
    logic        slot_err  [NS];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        core_if.qvalid    = 1'b0;
        core_if.pready    = 1'b0;
        mem_if.pvalid     = 1'b0;
        cyc();
        cyc();
        sb.delete();
        rst = 1'b0;
        #1;
    endtask

    // Issue one request; expected response is queued at issue time.
    task automatic issue(input logic [IW-1:0] id, input logic [31:0] addr, output int slot);
        logic [31:0] d;
        core_if.qvalid = 1'b1;
        core_if.qid    = id;
        core_if.qaddr  = addr;
        core_if.qwrite = 1'b0;
        core_if.qamo   = 4'h0;
        core_if.qdata  = ~addr;
        core_if.qstrb  = 4'hf;
        #1;
        slot = -1;
        for (int k = 0; k < 20; k++) begin
            if (core_if.qready) begin
                slot = int'(mem_if.qid) % NS;
                break;
            end
            cyc();
        end
        if (slot < 0) begin
            chk("issue_timeout", 32'd0, 32'd1);
            core_if.qvalid = 1'b0;
            return;
        end
        chk("mem_qaddr", mem_if.qaddr, addr);
        chk("mem_qdata", mem_if.qdata, ~addr);
        chk("mem_qvalid", 32'(mem_if.qvalid), 32'd1);
        d = {8'hD0, 8'(id), addr[15:0]};
        slot_data[slot] = d;
        slot_err[slot]  = id[0];
        sb.push_back('{id: id, data: d, err: id[0]});
        cyc();
        core_if.qvalid = 1'b0;
    endtask

    task automatic mem_resp(input int slot, input bit chk_no_bypass);
        mem_if.pvalid = 1'b1;
        mem_if.pid    = IW'(slot);
        mem_if.pdata  = slot_data[slot % NS];
        mem_if.perror = slot_err[slot % NS];
        if (chk_no_bypass) begin
            #1;
            chk("no_bypass", 32'(core_if.pvalid), 32'd0);
        end
        cyc();
        mem_if.pvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: every core response handshake pops and compares.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && core_if.pvalid && core_if.pready) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pid", 32'(core_if.pid), 32'(e.id));
                chk("pdata", core_if.pdata, e.data);
                chk("perror", 32'(core_if.perror), 32'(e.err));
            end
        end
    end

    initial begin
        int s;
        logic [IW-1:0] ids [4];
        exp_t e;
        ids = '{6'd3, 6'd7, 6'd1, 6'd9};

        core_if.qvalid = 1'b0;
        core_if.qaddr  = '0;
        core_if.qwrite = 1'b0;
        core_if.qamo   = '0;
        core_if.qdata  = '0;
        core_if.qstrb  = '0;
        core_if.qid    = '0;
        core_if.pready = 1'b0;
        mem_if.qready  = 1'b1;
        mem_if.pvalid  = 1'b0;
        mem_if.pdata   = '0;
        mem_if.perror  = 1'b0;
        mem_if.pid     = '0;
        for (int i = 0; i < int'(NS); i++) begin
            slot_data[i] = '0;
            slot_err[i]  = 1'b0;
        end

        // Reset state
        do_reset();
        chk("rst_pvalid", 32'(core_if.pvalid), 32'd0);
        chk("rst_spurious", 32'(spurious), 32'd0);
        chk("rst_mem_pready", 32'(mem_if.pready), 32'd1);
        chk("rst_mem_qid", 32'(mem_if.qid), 32'd0);
        mem_if.qready  = 1'b0;
        core_if.qvalid = 1'b1;
        #1;
        chk("rst_qready_lo", 32'(core_if.qready), 32'd0);
        chk("rst_mqvalid_hi", 32'(mem_if.qvalid), 32'd1);
        mem_if.qready = 1'b1;
        #1;
        chk("rst_qready_hi", 32'(core_if.qready), 32'd1);
        core_if.qvalid = 1'b0;
        #1;
        chk("rst_mqvalid_lo", 32'(mem_if.qvalid), 32'd0);
        cyc();

        // Four loads, responses in slot order 2,0,3,1
        core_if.pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ids[i], 32'h1000 + 32'(i * 4), s);
            chk("slot_idx", 32'(s), 32'(i));
        end
        mem_resp(2, 1'b1);
        mem_resp(0, 1'b1);
        mem_resp(3, 1'b0);
        mem_resp(1, 1'b0);
        drain();
        chk("t1_spurious", 32'(spurious), 32'd0);

        // Five back-to-back requests, memory silent
        do_reset();
        for (int i = 0; i < 4; i++) issue(6'(10 + i), 32'h2000 + 32'(i), s);
        core_if.qvalid = 1'b1;
        core_if.qid    = 6'd20;
        #1;
        chk("full_qready", 32'(core_if.qready), 32'd0);
        chk("full_mqvalid", 32'(mem_if.qvalid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("full_hold", 32'(core_if.qready), 32'd0);
`ifdef MEMPOOL_TCDM_ROB_STATS_EN
            chk("stall_cnt", stall_cnt, 32'(k + 1));
`endif
        end
        core_if.qvalid = 1'b0;

        // Full, head DONE, pop and request in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) issue(6'(30 + i), 32'h3000 + 32'(i), s);
        mem_resp(0, 1'b0);
        core_if.pready = 1'b1;
        core_if.qvalid = 1'b1;
        core_if.qid    = 6'd40;
        #1;
        chk("pop_cyc_pvalid", 32'(core_if.pvalid), 32'd1);
        chk("pop_cyc_qready", 32'(core_if.qready), 32'd0);
        cyc();
        core_if.pready = 1'b0;
        chk("next_cyc_qready", 32'(core_if.qready), 32'd1);
        chk("next_cyc_qid", 32'(mem_if.qid), 32'd0);
        issue(6'd40, 32'h3100, s);
        chk("wrap_slot", 32'(s), 32'd0);

        // Response for a FREE slot
        do_reset();
        slot_data[2] = 32'hBAD0_0002;
        mem_resp(2, 1'b0);
        chk("spur_set", 32'(spurious), 32'd1);
        chk("spur_pvalid", 32'(core_if.pvalid), 32'd0);
        cyc();
        cyc();
        cyc();
        chk("spur_sticky", 32'(spurious), 32'd1);
        chk("spur_pvalid2", 32'(core_if.pvalid), 32'd0);
        do_reset();
        chk("spur_cleared", 32'(spurious), 32'd0);

        // Back-pressure on a DONE head
        core_if.pready = 1'b0;
        issue(6'd21, 32'h4444, s);
        mem_resp(s, 1'b0);
        e = sb[0];
        for (int k = 0; k < 3; k++) begin
            chk("bp_pvalid", 32'(core_if.pvalid), 32'd1);
            chk("bp_pid", 32'(core_if.pid), 32'(e.id));
            chk("bp_pdata", core_if.pdata, e.data);
            cyc();
        end
        core_if.pready = 1'b1;
        drain();
        core_if.pready = 1'b0;

        // Reset with two requests pending, then their responses arrive
        do_reset();
        issue(6'd5, 32'h5000, s);
        issue(6'd6, 32'h5004, s);
        do_reset();
        chk("rst2_spurious", 32'(spurious), 32'd0);
        mem_resp(0, 1'b0);
        mem_resp(1, 1'b0);
        chk("rst2_spur_set", 32'(spurious), 32'd1);
        chk("rst2_pvalid", 32'(core_if.pvalid), 32'd0);
        core_if.qvalid = 1'b1;
        #1;
        chk("rst2_qready", 32'(core_if.qready), 32'd1);
        chk("rst2_qid", 32'(mem_if.qid), 32'd0);
        core_if.qvalid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mempool_tcdm_rob.md
MEMPOOL_TCDM_ROB -- requirements
Module: mempool_tcdm_rob

Interface
REQ-001 SHALL have parameter NumSlots, default 4, number of outstanding TCDM requests; power of two, 2..16.
REQ-002 SHALL have parameter MetaIdWidth, default snitch_pkg meta_id_t width, width of the core-side and memory-side id fields.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port core_qaddr_i / core_qwrite_i / core_qamo_i / core_qdata_i / core_qstrb_i  input  32/1/4/32/4  core request payload.
REQ-006 SHALL have port core_qid_i  input  MetaIdWidth  core request id.
REQ-007 SHALL have port core_qvalid_i  input  1 and port core_qready_o  output  1  core request handshake.
REQ-008 SHALL have port core_pdata_o / core_perror_o / core_pid_o  output  32/1/MetaIdWidth  in-order response to core.
REQ-009 SHALL have port core_pvalid_o  output  1 and port core_pready_i  input  1  core response handshake.
REQ-010 SHALL have port mem_qaddr_o / mem_qwrite_o / mem_qamo_o / mem_qdata_o / mem_qstrb_o  output  32/1/4/32/4  forwarded request payload.
REQ-011 SHALL have port mem_qid_o  output  MetaIdWidth  slot index, zero-extended.
REQ-012 SHALL have port mem_qvalid_o  output  1 and port mem_qready_i  input  1  memory request handshake.
REQ-013 SHALL have port mem_pdata_i / mem_perror_i / mem_pid_i / mem_pvalid_i  input  32/1/MetaIdWidth/1  out-of-order memory response.
REQ-014 SHALL have port mem_pready_o  output  1  memory response ready, constant 1.
REQ-015 SHALL have port spurious_o  output  1  sticky flag, response hit an unallocated slot.

Function
REQ-016 SHALL hold NumSlots slots, each with state {FREE, PEND, DONE}, stored core id, data and error; wr_ptr, rd_ptr and count are registered.
REQ-017 SHALL drive mem_qvalid_o = core_qvalid_i & (count < NumSlots), core_qready_o = mem_qready_i & (count < NumSlots), payload passed combinationally, zero latency.
REQ-018 SHALL, on request handshake, set slot[wr_ptr] to PEND, store core_qid_i, drive mem_qid_o = wr_ptr and increment wr_ptr modulo NumSlots.
REQ-019 SHALL, on mem_pvalid_i with slot[mem_pid_i] in PEND, capture data and error and set the slot to DONE; otherwise drop the beat and set spurious_o.
REQ-020 SHALL drive core_pvalid_o = (slot[rd_ptr] == DONE) with that slot's data, error and stored id; memory-response-to-core latency is at least 1 cycle, with no bypass.
REQ-021 SHALL, on core response handshake, set slot[rd_ptr] to FREE and increment rd_ptr modulo NumSlots.
REQ-022 SHALL compute count from registered state only: when full, an allocation is blocked even in a cycle where a pop occurs.
REQ-023 SHALL, on simultaneous allocate and pop, leave count unchanged; on simultaneous memory response and pop of different slots, perform both.
REQ-024 SHALL, when core_pready_i is low, hold core_pvalid_o and its payload stable.
REQ-025 SHALL keep core_pvalid_o asserted until the handshake once it is asserted.

Reset
REQ-026 SHALL, on rst_i, set all slots FREE, wr_ptr/rd_ptr/count to 0 and spurious_o to 0.
REQ-027 SHALL drive core_qready_o = mem_qready_i, mem_qvalid_o = core_qvalid_i and core_pvalid_o = 0 immediately after reset.
REQ-028 SHALL treat responses to requests issued before a reset as spurious: drop them and set spurious_o.

Configuration
REQ-029 SHALL, with macro MEMPOOL_TCDM_ROB_STATS_EN defined, add output full_stall_cnt_o (32 bits): counts cycles with core_qvalid_i high and count == NumSlots, saturates at 2^32-1 and resets to 0.
REQ-030 SHALL, without MEMPOOL_TCDM_ROB_STATS_EN, omit that port and counter, with no other behavioural change.

Structure
REQ-031 SHALL place the slot-state enum and the slot struct typedef in snitch_pkg; meta_id_t is reused from there.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 SHALL cover: 4 loads, ids 3,7,1,9, returned by memory in slot order 2,0,3,1 -> core receives ids 3,7,1,9 in issue order with the matching data.
REQ-034 SHALL cover: 5 back-to-back requests, memory never responds -> requests 1-4 are accepted and the 5th request sees core_qready_o=0 (with MEMPOOL_TCDM_ROB_STATS_EN, the counter increments each cycle).
REQ-035 SHALL cover: full ROB, head DONE, pop and new request in the same cycle -> new request blocked for that cycle and accepted in the next.
REQ-036 SHALL cover: mem_pvalid_i with id 2 while slot 2 is FREE -> no core response and spurious_o=1 until reset.
REQ-037 SHALL cover: core_pready_i held low for 3 cycles while the head is DONE -> core_pdata_o, core_pid_o and core_pvalid_o are stable across those cycles.
REQ-038 SHALL cover: rst_i asserted with 2 requests PEND, then their responses arrive -> responses are dropped, spurious_o=1 and count=0.
